sd_write: RTL and testbench

- SPI-mode single-block writer for the SD card; the write-side counterpart of the existing block reader.
- On request it performs CMD24 (WRITE_BLOCK), streams 512 payload bytes from a byte-wide source, checks the card's data-response token, and waits out the busy period.
- Sits beside the reader under the SD top level; the top-level mux routes SD_cs/SD_datain from this block while in its write state.
- SPI mode 0, MSB first.

---
 rtl/sd_write.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_sd_write.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_write.sv
// sd_write: SPI-mode single-block writer for an SD card (CMD24).
// On write_req (while init is high) it sends CMD24 with the latched card
// address, polls R1, sends the start token and 512 payload bytes pulled from
// a byte-wide valid/ready source, checks the data-response token and waits
// out the card's busy period. It then releases chip select with 8 trailing
// clocks and pulses write_o (success) or err with err_code (failure).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   init              card initialised; requests ignored while low
//   sec               card address (already scaled), latched on accept
//   write_req         one-clk start pulse
//   wr_data/wr_valid  payload byte source
//   wr_ready          byte taken this clk when wr_valid && wr_ready
//   busy              transaction in progress
//   write_o           one-clk pulse on success
//   err/err_code      one-clk failure pulse; err_code held until next accept
//                     (1 R1 timeout, 2 R1 nonzero, 3 CRC rejected,
//                      4 write error/other token, 5 busy timeout)
//   SD_clk, SD_cs, SD_datain, SD_dataout   SPI mode 0, MSB first
module sd_write #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned R1_TIMEOUT   = 8,
    parameter int unsigned BUSY_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [31:0] sec,
    input  logic        write_req,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        write_o,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        SD_clk,
    output logic        SD_cs,
    output logic        SD_datain,
    input  logic        SD_dataout
);

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0] R1_LIMIT   = 16'(R1_TIMEOUT);
    localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_R1,
        S_GAP,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_DRESP,
        S_BUSY,
        S_FIN,
        S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] sec_q, sec_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        write_o_q, write_o_d;
    logic        err_q, err_d;
    logic        cs_q, cs_d;

    // Byte engine state
    logic        active_q, active_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;

    logic        tick;
    logic        byte_done;
    logic        eng_idle;
    logic [15:0] cnt_inc;
    logic        start;
    logic [7:0]  start_byte;
    logic        ready_c;

    always_comb begin : engine_status
        tick      = (div_q == DIV_LAST);
        // The last falling edge of bit 7 ends the byte; rx_q is complete by then.
        byte_done = active_q && tick && sclk_q && (bit_q == 3'd7);
        eng_idle  = !active_q;
        cnt_inc   = cnt_q + 16'd1;
    end

    // Byte engine: SD_clk idles low; MOSI (tx_q[7]) is set up at load time and
    // advances on each falling edge, MISO is shifted in on each rising edge.
    always_comb begin : engine_next
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (active_q) begin
            if (tick) begin
                div_d  = '0;
                sclk_d = !sclk_q;
                if (!sclk_q) begin
                    rx_d = {rx_q[6:0], SD_dataout};
                end else begin
                    tx_d  = {tx_q[6:0], 1'b1};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end else if (start) begin
            active_d = 1'b1;
            tx_d     = start_byte;
            div_d    = '0;
            bit_d    = '0;
        end
    end

    // Sequencer. A new byte is launched the clk after byte_done, once the
    // state has advanced, so every state sees exactly one byte per completion.
    always_comb begin : fsm_next
        state_d    = state_q;
        cnt_d      = cnt_q;
        sec_d      = sec_q;
        err_code_d = err_code_q;
        write_o_d  = 1'b0;
        err_d      = 1'b0;
        start      = 1'b0;
        start_byte = 8'hFF;
        ready_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (write_req && init) begin
                    sec_d      = sec;
                    err_code_d = '0;
                    cnt_d      = '0;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                start = eng_idle;
                unique case (cnt_q[2:0])
                    3'd1:    start_byte = 8'h58;
                    3'd2:    start_byte = sec_q[31:24];
                    3'd3:    start_byte = sec_q[23:16];
                    3'd4:    start_byte = sec_q[15:8];
                    3'd5:    start_byte = sec_q[7:0];
                    default: start_byte = 8'hFF;
                endcase
                if (byte_done) begin
                    if (cnt_q == 16'd6) begin
                        cnt_d   = '0;
                        state_d = S_R1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_R1: begin
                start = eng_idle;
                if (byte_done) begin
                    if (!rx_q[7]) begin
                        if (rx_q == 8'h00) begin
                            state_d = S_GAP;
                        end else begin
                            state_d    = S_FAIL;
                            err_code_d = 3'd2;
                        end
                    end else if (cnt_inc == R1_LIMIT) begin
                        state_d    = S_FAIL;
                        err_code_d = 3'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_GAP: begin
                start = eng_idle;
                if (byte_done) begin
                    state_d = S_TOKEN;
                end
            end
            S_TOKEN: begin
                start      = eng_idle;
                start_byte = 8'hFE;
                if (byte_done) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                ready_c    = eng_idle;
                start      = eng_idle && wr_valid;
                start_byte = wr_data;
                if (byte_done) begin
                    if (cnt_q == 16'd511) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_CRC: begin
                start = eng_idle;
                if (byte_done) begin
                    if (cnt_q == 16'd1) begin
                        cnt_d   = '0;
                        state_d = S_DRESP;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_DRESP: begin
                start = eng_idle;
                if (byte_done) begin
                    if (rx_q != 8'hFF) begin
                        if (rx_q[4:0] == 5'b00101) begin
                            cnt_d   = '0;
                            state_d = S_BUSY;
                        end else if (rx_q[4:0] == 5'b01011) begin
                            state_d    = S_FAIL;
                            err_code_d = 3'd3;
                        end else begin
                            state_d    = S_FAIL;
                            err_code_d = 3'd4;
                        end
                    end else if (cnt_inc == R1_LIMIT) begin
                        state_d    = S_FAIL;
                        err_code_d = 3'd4;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_BUSY: begin
                start = eng_idle;
                if (byte_done) begin
                    if (rx_q == 8'hFF) begin
                        state_d = S_FIN;
                    end else if (cnt_inc == BUSY_LIMIT) begin
                        state_d    = S_FAIL;
                        err_code_d = 3'd5;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_FIN: begin
                start = eng_idle;
                if (byte_done) begin
                    write_o_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_FAIL: begin
                start = eng_idle;
                if (byte_done) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cs_d = (state_d == S_IDLE) || (state_d == S_FIN) || (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sec_q      <= '0;
            err_code_q <= '0;
            write_o_q  <= 1'b0;
            err_q      <= 1'b0;
            cs_q       <= 1'b1;
            active_q   <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            sclk_q     <= 1'b0;
            tx_q       <= '1;
            rx_q       <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sec_q      <= sec_d;
            err_code_q <= err_code_d;
            write_o_q  <= write_o_d;
            err_q      <= err_d;
            cs_q       <= cs_d;
            active_q   <= active_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    assign wr_ready  = ready_c;
    assign busy      = (state_q != S_IDLE);
    assign write_o   = write_o_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign SD_clk    = sclk_q;
    assign SD_cs     = cs_q;
    assign SD_datain = tx_q[7];

endmodule

// File: tb/tb_sd_write.sv
// Bench for sd_write: a byte-level SD card model answers each transaction
// from a configured script (R1 delay/value, data-response token, busy bytes),
// a payload source feeds pattern bytes with an optional stall, and the
// expected outcome code is derived from the card script.
module tb_sd_write;

    localparam int R1_TO   = 8;
    localparam int BUSY_TO = 16;

    logic        clk, rst, init, write_req, wr_valid, wr_ready;
    logic        busy, write_o, err, sd_clk, sd_cs, sd_datain, sd_dataout;
    logic [31:0] sec;
    logic [7:0]  wr_data;
    logic [2:0]  err_code;

    // card script
    int          r1_delay;
    logic [7:0]  r1_val;
    logic [7:0]  tok_val;
    int          nbusy;
    // card capture
    logic [7:0]  cmd_rx [7];
    logic [7:0]  data_rx [512];
    int          data_cnt, c_idx, post;
    bit          seen_tok;
    // source
    int          txn_id, src_hs, stall_at, stall_len;
    logic [7:0]  src_base;
    // monitor
    int          n_wo, n_err, both, rdy, sviol, got_end;
    int          tests, fails;

    sd_write #(.CLK_DIV(2), .R1_TIMEOUT(R1_TO), .BUSY_TIMEOUT(BUSY_TO)) dut (
        .clk(clk), .rst(rst), .init(init), .sec(sec), .write_req(write_req),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .write_o(write_o), .err(err), .err_code(err_code),
        .SD_clk(sd_clk), .SD_cs(sd_cs), .SD_datain(sd_datain),
        .SD_dataout(sd_dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Card model: samples MOSI on SD_clk rise, shifts MISO on SD_clk fall.
    initial begin : card
        int         bits;
        logic [7:0] sh, cur, nxt;
        logic       sclk_p, cs_p;
        bits = 0; sh = 8'hFF; cur = 8'hFF; sclk_p = 1'b0; cs_p = 1'b1;
        sd_dataout = 1'b1;
        c_idx = 0; data_cnt = 0; post = 0; seen_tok = 1'b0;
        forever begin
            @(sd_clk or sd_cs);
            if (cs_p && !sd_cs) begin
                bits = 0; c_idx = 0; data_cnt = 0; post = 0; seen_tok = 1'b0;
                cur = 8'hFF; sd_dataout = 1'b1;
                for (int i = 0; i < 7; i++) cmd_rx[i] = 8'h00;
            end
            if (sd_clk && !sclk_p) begin
                sh   = {sh[6:0], sd_datain};
                bits = bits + 1;
                if (bits == 8) begin
                    bits = 0;
                    nxt  = 8'hFF;
                    if (!sd_cs) begin
                        if (c_idx < 7) cmd_rx[c_idx] = sh;
                        if (seen_tok && data_cnt < 512) begin
                            data_rx[data_cnt] = sh;
                            data_cnt = data_cnt + 1;
                        end else if (data_cnt == 512) begin
                            post = post + 1;
                        end else if (c_idx >= 7 && sh == 8'hFE) begin
                            seen_tok = 1'b1;
                        end
                        c_idx = c_idx + 1;
                        if (!seen_tok && c_idx == 7 + r1_delay) nxt = r1_val;
                        else if (data_cnt == 512 && post == 2) nxt = tok_val;
                        else if (data_cnt == 512 && post >= 3 && post - 3 < nbusy) nxt = 8'h00;
                    end
                    cur = nxt;
                    sd_dataout = cur[7];
                end
            end else if (!sd_clk && sclk_p) begin
                if (bits != 0) begin
                    cur = {cur[6:0], 1'b1};
                    sd_dataout = cur[7];
                end
            end
            sclk_p = sd_clk;
            cs_p   = sd_cs;
        end
    end

    // Payload source: byte i of a transaction is src_base + i.
    initial begin : source
        int   seen, idx, stall_cnt;
        logic prev_hs;
        seen = 0; idx = 0; stall_cnt = 0; prev_hs = 1'b0; src_hs = 0;
        wr_valid = 1'b0; wr_data = 8'h00;
        forever begin
            @(negedge clk);
            if (txn_id != seen) begin
                seen = txn_id; idx = 0; src_hs = 0; stall_cnt = 0; prev_hs = 1'b0;
            end else if (prev_hs) begin
                idx = idx + 1;
                src_hs = src_hs + 1;
            end
            if (idx == stall_at && stall_cnt < stall_len) begin
                wr_valid  = 1'b0;
                stall_cnt = stall_cnt + 1;
            end else begin
                wr_valid = (idx < 512);
            end
            wr_data = 8'(int'(src_base) + idx);
            prev_hs = wr_valid && wr_ready;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_code(int d, logic [7:0] r1, logic [7:0] tk, int nb);
        if (d >= R1_TO || r1[7]) return 1;
        if (r1 != 8'h00) return 2;
        if (tk[4:0] == 5'b00101) return (nb >= BUSY_TO) ? 5 : 0;
        if (tk[4:0] == 5'b01011) return 3;
        return 4;
    endfunction

    task automatic start_txn(input logic [31:0] s, input int d, input logic [7:0] r1,
                             input logic [7:0] tk, input int nb, input logic [7:0] base,
                             input int st_at, input int st_len);
        r1_delay = d; r1_val = r1; tok_val = tk; nbusy = nb;
        src_base = base; stall_at = st_at; stall_len = st_len;
        txn_id = txn_id + 1;
        @(negedge clk);
        sec = s; write_req = 1'b1;
        @(negedge clk);
        write_req = 1'b0;
        sec = $urandom;
    endtask

    task automatic wait_end();
        int tail;
        n_wo = 0; n_err = 0; both = 0; rdy = 0; sviol = 0; got_end = 0; tail = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (wr_ready) rdy++;
            if (wr_ready && sd_clk) sviol++;
            if (write_o) n_wo++;
            if (err) n_err++;
            if (write_o && err) both++;
            if (write_o || err) got_end = 1;
            if (got_end != 0) begin
                tail++;
                if (tail > 5) break;
            end
        end
    endtask

    task automatic verify(input int code, input logic [31:0] s, input logic [7:0] base);
        logic [55:0] got_cmd;
        int bad;
        check("end_seen", 64'(got_end), 64'(1));
        check("write_o_cycles", 64'(n_wo), 64'(code == 0));
        check("err_cycles", 64'(n_err), 64'(code != 0));
        check("err_code_held", 64'(err_code), 64'(code));
        check("pulse_overlap", 64'(both), 64'(0));
        check("cs_busy_idle", 64'({sd_cs, busy}), 64'(2'b10));
        got_cmd = {cmd_rx[0], cmd_rx[1], cmd_rx[2], cmd_rx[3], cmd_rx[4], cmd_rx[5], cmd_rx[6]};
        check("cmd_bytes", 64'(got_cmd), 64'({8'hFF, 8'h58, s, 8'hFF}));
        if (code == 0 || code >= 3) begin
            bad = 0;
            for (int i = 0; i < 512; i++) begin
                if (data_rx[i] !== 8'(int'(base) + i)) bad++;
            end
            check("handshakes", 64'(src_hs), 64'(512));
            check("card_data_bytes", 64'(data_cnt), 64'(512));
            check("payload_mismatches", 64'(bad), 64'(0));
        end else begin
            check("handshakes", 64'(src_hs), 64'(0));
            check("ready_cycles", 64'(rdy), 64'(0));
        end
        check("sclk_low_when_ready", 64'(sviol), 64'(0));
    endtask

    initial begin : main
        logic [31:0] s;
        logic [7:0]  b, r1;
        int          d, reached, ab_pulses;
        tests = 0; fails = 0; txn_id = 0;
        rst = 1'b1; init = 1'b0; write_req = 1'b0; sec = '0;
        r1_delay = 0; r1_val = 8'h00; tok_val = 8'h05; nbusy = 0;
        src_base = 8'h00; stall_at = -1; stall_len = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({sd_clk, sd_cs, sd_datain, busy, write_o, err, err_code, wr_ready}),
              64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}));
        rst = 1'b0;

        // request ignored while init is low
        @(negedge clk); write_req = 1'b1;
        @(negedge clk); write_req = 1'b0;
        repeat (4) @(negedge clk);
        check("no_accept_without_init", 64'({busy, sd_cs}), 64'(2'b01));

        // nominal write with a 100-clk source stall at byte 200; init drops mid-way
        init = 1'b1;
        start_txn(32'h0000_1234, 0, 8'h00, 8'h05, 3, 8'h00, 200, 100);
        init = 1'b0;
        wait_end();
        init = 1'b1;
        verify(exp_code(0, 8'h00, 8'h05, 3), 32'h0000_1234, 8'h00);

        // card never answers: 8 polls then R1 timeout
        s = $urandom;
        start_txn(s, R1_TO, 8'hFF, 8'h05, 0, 8'h00, -1, 0);
        wait_end();
        verify(exp_code(R1_TO, 8'hFF, 8'h05, 0), s, 8'h00);

        // nonzero R1 on the last permitted poll
        s = $urandom; r1 = 8'($urandom_range(1, 127));
        start_txn(s, R1_TO - 1, r1, 8'h05, 0, 8'h00, -1, 0);
        wait_end();
        verify(exp_code(R1_TO - 1, r1, 8'h05, 0), s, 8'h00);

        // CRC rejected
        s = $urandom; b = 8'($urandom); d = $urandom_range(0, 3);
        start_txn(s, d, 8'h00, 8'h0B, 0, b, -1, 0);
        wait_end();
        verify(exp_code(d, 8'h00, 8'h0B, 0), s, b);

        // busy never released
        s = $urandom; b = 8'($urandom); d = $urandom_range(0, 3);
        start_txn(s, d, 8'h00, 8'h05, 1000, b, -1, 0);
        wait_end();
        verify(exp_code(d, 8'h00, 8'h05, 1000), s, b);

        // reset during byte 300 of the payload
        start_txn($urandom, 0, 8'h00, 8'h05, 3, 8'($urandom), -1, 0);
        reached = 0; ab_pulses = 0;
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if (write_o || err) ab_pulses++;
            if (src_hs >= 300) begin
                reached = 1;
                break;
            end
        end
        check("reach_data_byte_300", 64'(reached), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_cs_high", 64'(sd_cs), 64'(1));
        check("rst_busy_low", 64'(busy), 64'(0));
        check("rst_sclk_ready", 64'({sd_clk, wr_ready, err_code}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (write_o || err) ab_pulses++;
        end
        check("abort_pulses", 64'(ab_pulses), 64'(0));

        // clean transaction after the abort, write-error token
        s = $urandom; b = 8'($urandom); d = $urandom_range(0, 3);
        start_txn(s, d, 8'h00, 8'h0D, 0, b, -1, 0);
        wait_end();
        verify(exp_code(d, 8'h00, 8'h0D, 0), s, b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
